// File: rtl/contador_scheduler.sv
// Round-robin scheduler that time-shares one CW-bit interval counter among NREQ requesters.
// Each grant runs LOAD, then (limit+1) COUNT cycles, then a one-cycle DONE pulse to the owner.
module contador_scheduler #(
   parameter int NREQ = 4,
   parameter int CW   = 3
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*CW-1:0]   req_max,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic                 busy,
   output logic [CW-1:0]        cur_count
);

   localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   maxLat_q, maxLat_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic [SW-1:0]   rrLast_q, rrLast_d;

   logic [SW-1:0]   winner;
   logic [SW-1:0]   cand;
   logic            found;
   logic [CW-1:0]   limit [NREQ];

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         limit[i] = req_max[i*CW +: CW];
      end
   end

   // Search starts just after the last owner, so a re-requesting owner goes last.
   always_comb begin
      found  = 1'b0;
      winner = rrLast_q;
      cand   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = SW'((int'(rrLast_q) + k) % NREQ);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      maxLat_d = maxLat_q;
      sel_d    = sel_q;
      rrLast_d = rrLast_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d    = winner;
               rrLast_d = winner;
               maxLat_d = limit[winner];
               state_d  = LOAD;
            end
         end
         LOAD: begin
            count_d = '0;
            state_d = COUNT;
         end
         COUNT: begin
            // An owner dropping its request wins over a same-cycle completion.
            if (!req[sel_q]) begin
               count_d = '0;
               state_d = IDLE;
            end else if (count_q >= maxLat_q) begin
               state_d = DONE;
            end else begin
               count_d = count_q + CW'(1);
            end
         end
         DONE: begin
            count_d = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         count_q  <= '0;
         maxLat_q <= '0;
         sel_q    <= '0;
         rrLast_q <= SW'(NREQ - 1);
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         maxLat_q <= maxLat_d;
         sel_q    <= sel_d;
         rrLast_q <= rrLast_d;
      end
   end

   // Outputs decode registers only, so reset clears them without waiting for an edge.
   always_comb begin
      busy      = (state_q != IDLE);
      grant     = busy ? (ONE_HOT0 << sel_q) : '0;
      done      = (state_q == DONE) ? (ONE_HOT0 << sel_q) : '0;
      cur_count = count_q;
   end

endmodule

// File: tb/tb_contador_scheduler.sv
// Directed bench for contador_scheduler: single grants, round-robin order, abort,
// limit latching, no-wrap at the maximum limit and asynchronous reset mid-count.
module tb_contador_scheduler;

   localparam int NREQ = 4;
   localparam int CW   = 3;

   logic                clock = 1'b0;
   logic                reset;
   logic [NREQ-1:0]     req;
   logic [NREQ*CW-1:0]  reqMax;
   logic [NREQ-1:0]     grant;
   logic [NREQ-1:0]     done;
   logic                busy;
   logic [CW-1:0]       curCount;

   int nChecks = 0;
   int nErrors = 0;

   always #5 clock = ~clock;

   contador_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .req_max   (reqMax),
      .grant     (grant),
      .done      (done),
      .busy      (busy),
      .cur_count (curCount)
   );

   task automatic applyReset;
      reset  = 1'b1;
      req    = '0;
      reqMax = '0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset  = 1'b1;
      req    = '0;
      reqMax = '0;
      #1;
      nChecks++;
      if (grant !== 4'b0000) begin nErrors++; $display("[TB] FAIL reset_grant: got %b expected %b", grant, 4'b0000); end
      nChecks++;
      if (done !== 4'b0000) begin nErrors++; $display("[TB] FAIL reset_done: got %b expected %b", done, 4'b0000); end
      nChecks++;
      if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      nChecks++;
      if (curCount !== 3'd0) begin nErrors++; $display("[TB] FAIL reset_count: got %0d expected 0", curCount); end
      applyReset();
   endtask

   // Requester 0 alone with limit lim; optionally rewrite its limit during LOAD.
   task automatic test_single_limit(input int lim, input bit changeMax, input string tag);
      logic [CW-1:0] expCount;
      logic [NREQ-1:0] expDone;
      reqMax[2:0] = CW'(lim);
      req = 4'b0001;
      for (int c = 0; c <= lim + 2; c++) begin
         @(negedge clock);
         if (c == 0) expCount = 3'd0;
         else if (c <= lim + 1) expCount = CW'(c - 1);
         else expCount = CW'(lim);
         expDone = (c == lim + 2) ? 4'b0001 : 4'b0000;
         nChecks++;
         if (grant !== 4'b0001) begin nErrors++; $display("[TB] FAIL %s_grant c%0d: got %b expected %b", tag, c, grant, 4'b0001); end
         nChecks++;
         if (curCount !== expCount) begin nErrors++; $display("[TB] FAIL %s_count c%0d: got %0d expected %0d", tag, c, curCount, expCount); end
         nChecks++;
         if (done !== expDone) begin nErrors++; $display("[TB] FAIL %s_done c%0d: got %b expected %b", tag, c, done, expDone); end
         if (changeMax && c == 0) reqMax[2:0] = 3'd0;
         if (c == lim + 2) req = 4'b0000;
      end
      @(negedge clock);
      nChecks++;
      if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL %s_idle_busy: got %b expected 0", tag, busy); end
      nChecks++;
      if (grant !== 4'b0000) begin nErrors++; $display("[TB] FAIL %s_idle_grant: got %b expected %b", tag, grant, 4'b0000); end
   endtask

   task automatic test_round_robin;
      logic [NREQ-1:0] order [5];
      logic [NREQ-1:0] expDone;
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
      order[3] = 4'b1000; order[4] = 4'b0001;
      applyReset();
      reqMax = 12'b001_001_001_001;
      req    = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            expDone = (c == 3) ? order[g] : 4'b0000;
            nChecks++;
            if (grant !== order[g]) begin nErrors++; $display("[TB] FAIL rr_grant g%0d c%0d: got %b expected %b", g, c, grant, order[g]); end
            nChecks++;
            if (done !== expDone) begin nErrors++; $display("[TB] FAIL rr_done g%0d c%0d: got %b expected %b", g, c, done, expDone); end
         end
         if (g == 4) req = 4'b0000;
         @(negedge clock);
         nChecks++;
         if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL rr_gap g%0d: got busy %b expected 0", g, busy); end
      end
   endtask

   // Requester 1 (limit 5) aborts in its 2nd COUNT cycle; pending requester 2 follows.
   task automatic test_abort;
      reqMax = '0;
      reqMax[5:3] = 3'd5;
      reqMax[8:6] = 3'd1;
      req = 4'b0110;
      @(negedge clock);
      nChecks++;
      if (grant !== 4'b0010) begin nErrors++; $display("[TB] FAIL abort_load_grant: got %b expected %b", grant, 4'b0010); end
      @(negedge clock);
      nChecks++;
      if (curCount !== 3'd0) begin nErrors++; $display("[TB] FAIL abort_count1: got %0d expected 0", curCount); end
      @(negedge clock);
      nChecks++;
      if (curCount !== 3'd1) begin nErrors++; $display("[TB] FAIL abort_count2: got %0d expected 1", curCount); end
      req = 4'b0100;
      @(negedge clock);
      nChecks++;
      if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
      nChecks++;
      if (done !== 4'b0000) begin nErrors++; $display("[TB] FAIL abort_done: got %b expected %b", done, 4'b0000); end
      nChecks++;
      if (curCount !== 3'd0) begin nErrors++; $display("[TB] FAIL abort_count_clear: got %0d expected 0", curCount); end
      @(negedge clock);
      nChecks++;
      if (grant !== 4'b0100) begin nErrors++; $display("[TB] FAIL abort_next_grant: got %b expected %b", grant, 4'b0100); end
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      nChecks++;
      if (done !== 4'b0100) begin nErrors++; $display("[TB] FAIL abort_next_done: got %b expected %b", done, 4'b0100); end
      req = 4'b0000;
      @(negedge clock);
      nChecks++;
      if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL abort_final_busy: got %b expected 0", busy); end
   endtask

   task automatic test_async_reset;
      reqMax = '0;
      reqMax[2:0] = 3'd5;
      req = 4'b0001;
      repeat (4) @(negedge clock);
      nChecks++;
      if (curCount !== 3'd2) begin nErrors++; $display("[TB] FAIL areset_precount: got %0d expected 2", curCount); end
      #2 reset = 1'b1;
      #1;
      nChecks++;
      if (grant !== 4'b0000) begin nErrors++; $display("[TB] FAIL areset_grant: got %b expected %b", grant, 4'b0000); end
      nChecks++;
      if (busy !== 1'b0) begin nErrors++; $display("[TB] FAIL areset_busy: got %b expected 0", busy); end
      nChecks++;
      if (curCount !== 3'd0) begin nErrors++; $display("[TB] FAIL areset_count: got %0d expected 0", curCount); end
      nChecks++;
      if (done !== 4'b0000) begin nErrors++; $display("[TB] FAIL areset_done: got %b expected %b", done, 4'b0000); end
      @(negedge clock);
      reset  = 1'b0;
      reqMax = '0;
      req    = 4'b1111;
      @(negedge clock);
      nChecks++;
      if (grant !== 4'b0001) begin nErrors++; $display("[TB] FAIL areset_first_grant: got %b expected %b", grant, 4'b0001); end
      @(negedge clock);
      @(negedge clock);
      nChecks++;
      if (done !== 4'b0001) begin nErrors++; $display("[TB] FAIL areset_first_done: got %b expected %b", done, 4'b0001); end
      req = 4'b0000;
      @(negedge clock);
   endtask

   initial begin
      test_reset();
      test_single_limit(3, 1'b0, "lim3");
      test_single_limit(0, 1'b0, "lim0");
      test_round_robin();
      test_abort();
      test_single_limit(7, 1'b1, "lim7");
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
